// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a word-addressed data memory.
// Latency: error 1 cycle, load/word store 2 cycles, sub-word store 3 cycles (accept to resp_valid).
// Backpressure: req_ready only in IDLE; one request in flight, responses cannot be stalled.
module mem_access_unit #(
  parameter int          DEPTH    = 100,
  parameter logic [31:0] ERR_CODE = 32'h0000_DEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_memwrite,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured request fields. Only the lane bits of the address and the low
  // half of the store data are needed after capture: dm_addr keeps the word
  // index and full-word store data goes straight into dm_wd.
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = req_valid && req_ready;

  // Request legality, evaluated on the raw inputs so the decision is made at capture.
  always_comb begin
    req_err = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            || ({2'b00, req_addr[31:2]} >= DEPTH_W);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake/strobe outputs. The write strobe is also gated by
  // rst so an in-flight write is killed before the next edge.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    dm_memwrite = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                 state_nxt = RESP;
          else if (!req_write)         state_nxt = LOAD;
          else if (req_size == 2'b10)  state_nxt = WRITE;
          else                         state_nxt = MERGE;
        end
      end
      LOAD:  state_nxt = RESP;
      MERGE: state_nxt = WRITE;
      WRITE: begin
        dm_memwrite = !rst;
        state_nxt   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction with sign/zero extension, and lane insertion for sub-word stores.
  always_comb begin
    lane_byte = dm_rd[{lane_q, 3'b000} +: 8];
    lane_half = dm_rd[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_val = dm_rd;
    endcase
    merge_val = dm_rd;
    if (size_q == 2'b00) merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Request capture, memory-side registers and response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      wdata_q    <= 16'h0000;
      dm_addr    <= 32'h0000_0000;
      dm_wd      <= 32'h0000_0000;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lane_q   <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        wdata_q  <= req_wdata[15:0];
        dm_addr  <= {2'b00, req_addr[31:2]};
        if (req_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= ERR_CODE;
        end else if (req_write && req_size == 2'b10) begin
          dm_wd <= req_wdata;
        end
      end
      case (state)
        LOAD: begin
          resp_rdata <= load_val;
          resp_err   <= 1'b0;
        end
        MERGE: dm_wd <= merge_val;
        WRITE: begin
          resp_rdata <= 32'h0000_0000;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
